// File: rtl/store_write_buffer.sv
// Store write buffer: queues CPU stores in a small FIFO and drains them to data
// memory over a we/ack handshake; flags loads that overlap any pending store.
module store_write_buffer #(
    parameter int AW    = 32,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       st_valid,
    output logic                       st_ready,
    input  logic [AW-1:0]              st_addr,
    input  logic [31:0]                st_data,
    input  logic [3:0]                 st_be,
    output logic                       mem_we,
    output logic [AW-1:0]              mem_addr,
    output logic [31:0]                mem_wdata,
    output logic [3:0]                 mem_be,
    input  logic                       mem_ack,
    input  logic                       ld_valid,
    input  logic [AW-1:0]              ld_addr,
    output logic                       ld_hazard,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [CW-1:0] ONE_CNT  = CW'(1);
    localparam logic [PW-1:0] ONE_PTR  = PW'(1);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        WRITE = 1'b1
    } state_t;

    state_t          state_r;
    state_t          state_s;
    logic [PW-1:0]   wr_ptr_r;
    logic [PW-1:0]   rd_ptr_r;
    logic [CW-1:0]   count_r;
    logic [AW-1:0]   addr_q_r [DEPTH];
    logic [31:0]     data_q_r [DEPTH];
    logic [3:0]      be_q_r   [DEPTH];
    logic            mem_we_r;
    logic [AW-1:0]   mem_addr_r;
    logic [31:0]     mem_wdata_r;
    logic [3:0]      mem_be_r;

    logic            st_ready_s;
    logic            push_s;
    logic            pop_s;
    logic            load_s;
    logic            drop_we_s;
    logic [PW-1:0]   load_idx_s;
    logic            hit_s;

    // An all-zero byte enable completes the handshake without occupying a slot.
    assign st_ready_s = (count_r != FULL_CNT);
    assign push_s     = st_valid && st_ready_s && (st_be != 4'b0000);

    assign st_ready  = st_ready_s;
    assign empty     = (count_r == {CW{1'b0}});
    assign count     = count_r;
    assign mem_we    = mem_we_r;
    assign mem_addr  = mem_addr_r;
    assign mem_wdata = mem_wdata_r;
    assign mem_be    = mem_be_r;
    assign ld_hazard = hit_s;

    // FIFO storage and write pointer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= {PW{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                addr_q_r[i] <= {AW{1'b0}};
                data_q_r[i] <= 32'h0000_0000;
                be_q_r[i]   <= 4'b0000;
            end
        end else if (push_s) begin
            addr_q_r[wr_ptr_r] <= st_addr;
            data_q_r[wr_ptr_r] <= st_data;
            be_q_r[wr_ptr_r]   <= st_be;
            wr_ptr_r           <= wr_ptr_r + ONE_PTR;
        end else begin
            wr_ptr_r <= wr_ptr_r;
        end
    end

    // Read pointer and occupancy; the in-flight entry stays counted until acked
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_r <= {PW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + ONE_PTR;
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + ONE_CNT;
                2'b01:   count_r <= count_r - ONE_CNT;
                default: count_r <= count_r;
            endcase
        end
    end

    // Drain FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Drain FSM next state; on ack with entries left, the next head loads on the same edge
    always_comb begin
        state_s    = state_r;
        load_s     = 1'b0;
        pop_s      = 1'b0;
        drop_we_s  = 1'b0;
        load_idx_s = rd_ptr_r;
        case (state_r)
            IDLE: begin
                if (count_r != {CW{1'b0}}) begin
                    load_s  = 1'b1;
                    state_s = WRITE;
                end else begin
                    state_s = IDLE;
                end
            end
            WRITE: begin
                if (mem_ack) begin
                    pop_s = 1'b1;
                    if (count_r > ONE_CNT) begin
                        load_s     = 1'b1;
                        load_idx_s = rd_ptr_r + ONE_PTR;
                        state_s    = WRITE;
                    end else begin
                        drop_we_s = 1'b1;
                        state_s   = IDLE;
                    end
                end else begin
                    state_s = WRITE;
                end
            end
            default: begin
                drop_we_s = 1'b1;
                state_s   = IDLE;
            end
        endcase
    end

    // Memory-side write registers, held stable while waiting for ack
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_we_r    <= 1'b0;
            mem_addr_r  <= {AW{1'b0}};
            mem_wdata_r <= 32'h0000_0000;
            mem_be_r    <= 4'b0000;
        end else if (load_s) begin
            mem_we_r    <= 1'b1;
            mem_addr_r  <= addr_q_r[load_idx_s];
            mem_wdata_r <= data_q_r[load_idx_s];
            mem_be_r    <= be_q_r[load_idx_s];
        end else if (drop_we_s) begin
            mem_we_r <= 1'b0;
        end else begin
            mem_we_r <= mem_we_r;
        end
    end

    // Word-granular load overlap check against every occupied slot
    always_comb begin
        hit_s = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            hit_s = hit_s
                  | (({1'b0, PW'(i) - rd_ptr_r} < count_r)
                     && (addr_q_r[i][AW-1:2] == ld_addr[AW-1:2]));
        end
        hit_s = hit_s & ld_valid;
    end

endmodule

// File: tb/tb_store_write_buffer.sv
// Self-checking bench for store_write_buffer: vector table, directed corner
// sequences and randomized traffic against a queue-based reference model.
module tb_store_write_buffer;

    localparam int AW    = 32;
    localparam int DEPTH = 4;

    logic        clk;
    logic        rst_n;
    logic        st_valid;
    logic        st_ready;
    logic [31:0] st_addr;
    logic [31:0] st_data;
    logic [3:0]  st_be;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ack;
    logic        ld_valid;
    logic [31:0] ld_addr;
    logic        ld_hazard;
    logic        empty;
    logic [2:0]  count;

    int n_tests = 0;
    int n_fail  = 0;

    store_write_buffer #(.AW(AW), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .st_valid(st_valid), .st_ready(st_ready),
        .st_addr(st_addr), .st_data(st_data), .st_be(st_be),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_be(mem_be), .mem_ack(mem_ack),
        .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_hazard(ld_hazard),
        .empty(empty), .count(count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        sv;
        logic [31:0] sa;
        logic [31:0] sd;
        logic [3:0]  sb;
        logic        ack;
        logic        lv;
        logic [31:0] la;
        logic        e_we;
        logic [2:0]  e_cnt;
        logic        e_empty;
        logic        e_rdy;
        logic        e_hz;
        logic [31:0] e_addr;
        logic [31:0] e_data;
    } vec_t;

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  be;
    } ent_t;

    ent_t mq[$];
    bit   m_fly;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic drive(input logic sv, input logic [31:0] sa, input logic [31:0] sd,
                         input logic [3:0] sb, input logic ack, input logic lv,
                         input logic [31:0] la);
        st_valid = sv; st_addr = sa; st_data = sd; st_be = sb;
        mem_ack = ack; ld_valid = lv; ld_addr = la;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic bit model_hazard(input logic lv, input logic [31:0] la);
        bit h = 1'b0;
        foreach (mq[i]) if (mq[i].a[31:2] == la[31:2]) h = 1'b1;
        return h && lv;
    endfunction

    // One clock of traffic checked against the queue model, then the model advances.
    task automatic model_cycle(input logic sv, input logic [31:0] sa, input logic [31:0] sd,
                               input logic [3:0] sb, input logic ack, input logic lv,
                               input logic [31:0] la);
        int   old;
        bit   push;
        bit   popn;
        ent_t e;
        drive(sv, sa, sd, sb, ack, lv, la);
        #1;
        old = mq.size();
        chk("m_st_ready", st_ready, old < DEPTH);
        chk("m_count", count, old);
        chk("m_empty", empty, old == 0);
        chk("m_mem_we", mem_we, m_fly);
        chk("m_ld_hazard", ld_hazard, model_hazard(lv, la));
        if (m_fly) begin
            chk("m_mem_addr", mem_addr, mq[0].a);
            chk("m_mem_wdata", mem_wdata, mq[0].d);
            chk("m_mem_be", mem_be, mq[0].be);
        end
        push = sv && (old < DEPTH) && (sb != 4'b0000);
        popn = m_fly && ack;
        step();
        if (popn) begin
            void'(mq.pop_front());
            m_fly = (old > 1);
        end else if (!m_fly && old > 0) begin
            m_fly = 1'b1;
        end
        if (push) begin
            e.a = sa; e.d = sd; e.be = sb;
            mq.push_back(e);
        end
    endtask

    vec_t vt[10];

    initial begin
        logic [31:0] pool_a;
        rst_n = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b1, 32'h0000_0000);
        #12;
        chk("rst_mem_we", mem_we, 1'b0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_mem_wdata", mem_wdata, 32'h0);
        chk("rst_mem_be", mem_be, 4'h0);
        chk("rst_count", count, 3'd0);
        chk("rst_st_ready", st_ready, 1'b1);
        chk("rst_empty", empty, 1'b1);
        chk("rst_ld_hazard", ld_hazard, 1'b0);
        #8 rst_n = 1'b1;
        step();

        // single store held 3 cycles, then ack; then a be=0 store
        vt[0] = '{1'b1, 32'h100, 32'hDEADBEEF, 4'hF, 1'b0, 1'b0, 32'h0,   1'b0, 3'd0, 1'b1, 1'b1, 1'b0, 32'h0,   32'h0};
        vt[1] = '{1'b0, 32'h0,   32'h0,        4'h0, 1'b0, 1'b1, 32'h102, 1'b0, 3'd1, 1'b0, 1'b1, 1'b1, 32'h0,   32'h0};
        vt[2] = '{1'b0, 32'h0,   32'h0,        4'h0, 1'b0, 1'b0, 32'h0,   1'b1, 3'd1, 1'b0, 1'b1, 1'b0, 32'h100, 32'hDEADBEEF};
        vt[3] = '{1'b0, 32'h0,   32'h0,        4'h0, 1'b0, 1'b0, 32'h0,   1'b1, 3'd1, 1'b0, 1'b1, 1'b0, 32'h100, 32'hDEADBEEF};
        vt[4] = '{1'b0, 32'h0,   32'h0,        4'h0, 1'b0, 1'b1, 32'h104, 1'b1, 3'd1, 1'b0, 1'b1, 1'b0, 32'h100, 32'hDEADBEEF};
        vt[5] = '{1'b0, 32'h0,   32'h0,        4'h0, 1'b1, 1'b0, 32'h0,   1'b1, 3'd1, 1'b0, 1'b1, 1'b0, 32'h100, 32'hDEADBEEF};
        vt[6] = '{1'b0, 32'h0,   32'h0,        4'h0, 1'b0, 1'b1, 32'h102, 1'b0, 3'd0, 1'b1, 1'b1, 1'b0, 32'h0,   32'h0};
        vt[7] = '{1'b1, 32'h300, 32'h12345678, 4'h0, 1'b0, 1'b0, 32'h0,   1'b0, 3'd0, 1'b1, 1'b1, 1'b0, 32'h0,   32'h0};
        vt[8] = '{1'b0, 32'h0,   32'h0,        4'h0, 1'b0, 1'b1, 32'h300, 1'b0, 3'd0, 1'b1, 1'b1, 1'b0, 32'h0,   32'h0};
        vt[9] = '{1'b0, 32'h0,   32'h0,        4'h0, 1'b0, 1'b0, 32'h0,   1'b0, 3'd0, 1'b1, 1'b1, 1'b0, 32'h0,   32'h0};
        for (int k = 0; k < 10; k++) begin
            drive(vt[k].sv, vt[k].sa, vt[k].sd, vt[k].sb, vt[k].ack, vt[k].lv, vt[k].la);
            #1;
            chk($sformatf("vec%0d_mem_we", k), mem_we, vt[k].e_we);
            chk($sformatf("vec%0d_count", k), count, vt[k].e_cnt);
            chk($sformatf("vec%0d_empty", k), empty, vt[k].e_empty);
            chk($sformatf("vec%0d_st_ready", k), st_ready, vt[k].e_rdy);
            chk($sformatf("vec%0d_ld_hazard", k), ld_hazard, vt[k].e_hz);
            if (vt[k].e_we) begin
                chk($sformatf("vec%0d_mem_addr", k), mem_addr, vt[k].e_addr);
                chk($sformatf("vec%0d_mem_wdata", k), mem_wdata, vt[k].e_data);
            end
            step();
        end

        // fill to DEPTH, refused 5th push, then back-to-back drain
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 32'h10 + 32'(4 * i), 32'hA0 + 32'(i), 4'hF, 1'b0, 1'b0, 32'h0);
            step();
        end
        drive(1'b1, 32'h20, 32'hBAD, 4'hF, 1'b0, 1'b0, 32'h0);
        #1;
        chk("fill_count", count, 3'd4);
        chk("fill_st_ready", st_ready, 1'b0);
        step();
        drive(1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 1'b0, 32'h0);
        #1;
        chk("fill_count_after_refused", count, 3'd4);
        for (int k = 0; k < 4; k++) begin
            if (k != 0) #1;
            chk($sformatf("drain%0d_mem_we", k), mem_we, 1'b1);
            chk($sformatf("drain%0d_mem_addr", k), mem_addr, 32'h10 + 32'(4 * k));
            step();
        end
        drive(1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 32'h0);
        #1;
        chk("drain_done_mem_we", mem_we, 1'b0);
        chk("drain_done_empty", empty, 1'b1);

        // hazard on pending store, cleared after its ack
        drive(1'b1, 32'h200, 32'h55, 4'h1, 1'b0, 1'b0, 32'h0);
        step();
        drive(1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b1, 32'h203);
        #1;
        chk("hz_same_word", ld_hazard, 1'b1);
        ld_addr = 32'h204;
        #1;
        chk("hz_next_word", ld_hazard, 1'b0);
        step();
        drive(1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 1'b0, 32'h0);
        #1;
        chk("hz_mem_we", mem_we, 1'b1);
        chk("hz_mem_be", mem_be, 4'h1);
        step();
        drive(1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b1, 32'h203);
        #1;
        chk("hz_after_ack", ld_hazard, 1'b0);
        chk("hz_after_ack_empty", empty, 1'b1);
        step();

        // wrap: six pushes interleaved with acks, model tracks order
        mq.delete();
        m_fly = 1'b0;
        for (int i = 0; i < 6; i++) begin
            model_cycle(1'b1, 32'h400 + 32'(4 * i), 32'hC0 + 32'(i), 4'hF, i[0], 1'b1, 32'h404);
            model_cycle(1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 1'b0, 32'h0);
        end
        for (int i = 0; i < 8; i++) model_cycle(1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 1'b0, 32'h0);

        // randomized traffic against the reference model
        for (int c = 0; c < 1500; c++) begin
            pool_a = {24'h0, 3'($urandom_range(0, 5)) , 5'h0} + 32'h40 + 32'($urandom_range(0, 3));
            model_cycle(($urandom % 3) != 0, pool_a, $urandom, 4'($urandom_range(0, 15)),
                        $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                        {24'h0, 3'($urandom_range(0, 5)), 5'h0} + 32'h40 + 32'($urandom_range(0, 3)));
        end

        // reset asserted mid-write drops mem_we immediately
        drive(1'b1, 32'h80, 32'h77, 4'hF, 1'b0, 1'b0, 32'h0);
        step();
        drive(1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 6; i++) step();
        chk("midrst_pre_we", mem_we, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("midrst_mem_we", mem_we, 1'b0);
        chk("midrst_count", count, 3'd0);
        chk("midrst_st_ready", st_ready, 1'b1);
        chk("midrst_empty", empty, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        #1;
        chk("post_rst_mem_we", mem_we, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
